// File: rtl/wshb_arbiter_rr.sv
// wshb_arbiter_rr: N-master Wishbone B4 classic arbiter with round-robin grant.
// Sits between the video-path masters and the single SDRAM slave port.
// The owner's request fields are muxed to the slave. Terminations are routed
// back combinationally. Ownership moves only when the owner drops m_cyc.
// Optional feature macro: WSHB_ARB_QUANTUM_EN. When it is defined, an owner
// that has collected QUANTUM acks can be pre-empted at a transfer boundary.
module wshb_arbiter_rr #(
    parameter int NM      = 2,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int QUANTUM = 16
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic [NM-1:0]         m_cyc,
    input  logic [NM-1:0]         m_stb,
    input  logic [NM-1:0]         m_we,
    input  logic [NM*AW-1:0]      m_adr,
    input  logic [NM*DW-1:0]      m_dat_ms,
    input  logic [NM*(DW/8)-1:0]  m_sel,
    input  logic [NM*3-1:0]       m_cti,
    input  logic [NM*2-1:0]       m_bte,
    output logic [NM-1:0]         m_ack,
    output logic [NM-1:0]         m_err,
    output logic [NM-1:0]         m_rty,
    output logic [DW-1:0]         m_dat_sm,
    output logic                  s_cyc,
    output logic                  s_stb,
    output logic                  s_we,
    output logic [AW-1:0]         s_adr,
    output logic [DW-1:0]         s_dat_ms,
    output logic [DW/8-1:0]       s_sel,
    output logic [2:0]            s_cti,
    output logic [1:0]            s_bte,
    input  logic                  s_ack,
    input  logic                  s_err,
    input  logic                  s_rty,
    input  logic [DW-1:0]         s_dat_sm,
    output logic [NM-1:0]         grant
);

    localparam int IW = (NM > 1) ? $clog2(NM) : 1;

    typedef enum logic {
        IDLE,
        OWNED
    } state_e;

    state_e          state_q, state_d;
    logic [NM-1:0]   grant_q, grant_d;
    // Index of the current (or most recent) owner. While OWNED it selects the mux.
    logic [IW-1:0]   last_q, last_d;

    logic            owner_cyc;
    logic            arb_point;
    logic            preempt;
    logic            found;
    logic [IW-1:0]   next_idx;
    logic [IW-1:0]   cand_idx;

    assign owner_cyc = m_cyc[last_q];

`ifdef WSHB_ARB_QUANTUM_EN
    localparam logic [7:0] QUANTUM_C = 8'(QUANTUM);

    logic [7:0] qcnt_q, qcnt_d;
    logic [7:0] qcnt_inc;
    logic [2:0] owner_cti;
    logic       owner_ack;
    logic       others_waiting;

    assign owner_ack      = (state_q == OWNED) && s_ack;
    assign owner_cti      = m_cti[last_q*3 +: 3];
    assign others_waiting = |(m_cyc & ~grant_q);
    // Saturating count that includes the ack in flight. Pre-emption therefore
    // lands on the edge of the QUANTUM-th ack, not the one after it.
    assign qcnt_inc       = (qcnt_q == 8'hFF) ? qcnt_q : qcnt_q + 8'd1;

    // Pre-empt only at a transfer boundary (classic or end-of-burst cycle type).
    always_comb begin
        preempt = owner_ack && (qcnt_inc >= QUANTUM_C) && others_waiting &&
                  ((owner_cti == 3'b000) || (owner_cti == 3'b111));
    end

    // Ack counter for the current owner; restarts at every arbitration point.
    always_comb begin
        qcnt_d = qcnt_q;
        if (arb_point) begin
            qcnt_d = 8'd0;
        end else if (owner_ack) begin
            qcnt_d = qcnt_inc;
        end
    end

    // Quantum counter register.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            qcnt_q <= 8'd0;
        end else begin
            qcnt_q <= qcnt_d;
        end
    end
`else
    // QUANTUM only matters when pre-emption is compiled in.
    logic [7:0] unused_quantum;
    assign unused_quantum = 8'(QUANTUM);
    assign preempt        = 1'b0;
`endif

    assign arb_point = (state_q == IDLE) || !owner_cyc || preempt;

    // Round-robin search: first m_cyc requester from last_q+1 upward, wrapping.
    always_comb begin
        // NOTE: every variable written here is given a default first so that no path leaves it unassigned and infers a latch.
        found    = 1'b0;
        next_idx = last_q;
        cand_idx = last_q;
        for (int i = 1; i <= NM; i++) begin
            cand_idx = IW'(((int'(last_q) + i) >= NM) ? (int'(last_q) + i - NM)
                                                      : (int'(last_q) + i));
            if (!found && m_cyc[cand_idx]) begin
                found    = 1'b1;
                next_idx = cand_idx;
            end
        end
    end

    // Next-state logic: grant moves only at an arbitration point.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        if (arb_point) begin
            if (found) begin
                state_d = OWNED;
                grant_d = {{(NM-1){1'b0}}, 1'b1} << next_idx;
                last_d  = next_idx;
            end else begin
                state_d = IDLE;
                grant_d = '0;
            end
        end
    end

    // State register. Reset makes master 0 the first winner.
    always_ff @(posedge sys_clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together from pre-edge values.
        if (sys_rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= IW'(NM - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    // Output logic: mux the owner to the slave and route terminations back to it alone.
    always_comb begin
        s_cyc    = 1'b0;
        s_stb    = 1'b0;
        s_we     = 1'b0;
        s_adr    = '0;
        s_dat_ms = '0;
        s_sel    = '0;
        s_cti    = '0;
        s_bte    = '0;
        m_ack    = '0;
        m_err    = '0;
        m_rty    = '0;
        if (state_q == OWNED) begin
            s_cyc         = m_cyc[last_q];
            s_stb         = m_stb[last_q];
            s_we          = m_we[last_q];
            s_adr         = m_adr[last_q*AW +: AW];
            s_dat_ms      = m_dat_ms[last_q*DW +: DW];
            s_sel         = m_sel[last_q*(DW/8) +: (DW/8)];
            s_cti         = m_cti[last_q*3 +: 3];
            s_bte         = m_bte[last_q*2 +: 2];
            m_ack[last_q] = s_ack;
            m_err[last_q] = s_err;
            m_rty[last_q] = s_rty;
        end
    end

    assign m_dat_sm = s_dat_sm;
    assign grant    = grant_q;

endmodule

// File: tb/tb_wshb_arbiter_rr.sv
// Self-checking bench for wshb_arbiter_rr (NM=3, QUANTUM=4).
// Expectations follow WSHB_ARB_QUANTUM_EN when the bench is built with it.
module tb_wshb_arbiter_rr;

    localparam int NM = 3;
    localparam int AW = 32;
    localparam int DW = 32;

    logic              sys_clk = 1'b0;
    logic              sys_rst = 1'b1;
    logic [NM-1:0]     m_cyc = '0, m_stb = '0, m_we = '0;
    logic [NM*AW-1:0]  m_adr = '0;
    logic [NM*DW-1:0]  m_dat_ms = '0;
    logic [NM*4-1:0]   m_sel = '0;
    logic [NM*3-1:0]   m_cti = '0;
    logic [NM*2-1:0]   m_bte = '0;
    logic [NM-1:0]     m_ack, m_err, m_rty;
    logic [DW-1:0]     m_dat_sm;
    logic              s_cyc, s_stb, s_we;
    logic [AW-1:0]     s_adr;
    logic [DW-1:0]     s_dat_ms;
    logic [3:0]        s_sel;
    logic [2:0]        s_cti;
    logic [1:0]        s_bte;
    logic              s_ack = 1'b0, s_err = 1'b0, s_rty = 1'b0;
    logic [DW-1:0]     s_dat_sm = 32'hDEADBEEF;
    logic [NM-1:0]     grant;

    int checks = 0;
    int errors = 0;

    wshb_arbiter_rr #(.NM(NM), .AW(AW), .DW(DW), .QUANTUM(4)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr),
        .m_dat_ms(m_dat_ms), .m_sel(m_sel), .m_cti(m_cti), .m_bte(m_bte),
        .m_ack(m_ack), .m_err(m_err), .m_rty(m_rty), .m_dat_sm(m_dat_sm),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
        .s_dat_ms(s_dat_ms), .s_sel(s_sel), .s_cti(s_cti), .s_bte(s_bte),
        .s_ack(s_ack), .s_err(s_err), .s_rty(s_rty), .s_dat_sm(s_dat_sm),
        .grant(grant)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        string      name;
        logic       rst;
        logic [2:0] cyc, stb, we;
        logic       ack, err, rty;
        logic [2:0] exp_grant, exp_ack, exp_err, exp_rty;
        logic       exp_s_cyc, exp_s_stb;
    } vec_t;

    vec_t vecs[$];

    // Per-master constant request fields.
    function automatic logic [31:0] adr_of(input int i);
        return 32'h1000_0000 + 32'(i) * 32'h40;
    endfunction
    function automatic logic [31:0] dat_of(input int i);
        return 32'hA5A5_0000 + 32'(i);
    endfunction
    function automatic logic [3:0] sel_of(input int i);
        logic [3:0] one;
        one = 4'b0001;
        return one << i;
    endfunction
    function automatic logic [2:0] cti_of(input int i, input bit burst);
        return (burst && i == 1) ? 3'b010 : 3'b000;
    endfunction
    function automatic int owner_of(input logic [2:0] g);
        for (int i = 0; i < NM; i++) begin
            if (g == (3'b001 << i)) return i;
        end
        return -1;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_static(input bit burst);
        for (int i = 0; i < NM; i++) begin
            m_adr[i*AW +: AW]    = adr_of(i);
            m_dat_ms[i*DW +: DW] = dat_of(i);
            m_sel[i*4 +: 4]      = sel_of(i);
            m_cti[i*3 +: 3]      = cti_of(i, burst);
            m_bte[i*2 +: 2]      = 2'(i);
        end
    endtask

    task automatic do_reset();
        @(negedge sys_clk);
        sys_rst = 1'b1;
        m_cyc = '0; m_stb = '0; m_we = '0;
        s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
        repeat (2) @(negedge sys_clk);
        sys_rst = 1'b0;
    endtask

    task automatic add(input string n, input logic rst, input logic [2:0] cyc, stb, we,
                       input logic ack, err, rty,
                       input logic [2:0] eg, ea, ee, er, input logic esc, ess);
        vec_t v;
        v.name = n; v.rst = rst; v.cyc = cyc; v.stb = stb; v.we = we;
        v.ack = ack; v.err = err; v.rty = rty;
        v.exp_grant = eg; v.exp_ack = ea; v.exp_err = ee; v.exp_rty = er;
        v.exp_s_cyc = esc; v.exp_s_stb = ess;
        vecs.push_back(v);
    endtask

    int          acks[NM];
    int          ten[NM];
    bit          drop[NM];
    int          owners[$];
    logic [2:0]  prev_g;
    int          idle_cycles;
    bit          rr_done;
    logic [2:0]  q_exp;

    initial begin
        //   name        rst cyc     stb     we      a  e  r   grant   ack     err     rty     scyc sstb
        add("t1_req",    0, 3'b001, 3'b001, 3'b000, 0, 0, 0, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0);
        add("t1_wait1",  0, 3'b001, 3'b000, 3'b000, 0, 0, 0, 3'b001, 3'b000, 3'b000, 3'b000, 1, 0);
        add("t1_wait2",  0, 3'b001, 3'b001, 3'b000, 0, 0, 0, 3'b001, 3'b000, 3'b000, 3'b000, 1, 1);
        add("t1_ack",    0, 3'b001, 3'b001, 3'b000, 1, 0, 0, 3'b001, 3'b001, 3'b000, 3'b000, 1, 1);
        add("t1_drop",   0, 3'b000, 3'b000, 3'b000, 0, 0, 0, 3'b001, 3'b000, 3'b000, 3'b000, 0, 0);
        add("t1_idle",   0, 3'b000, 3'b000, 3'b000, 0, 0, 0, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0);
        add("t2_rst",    1, 3'b000, 3'b000, 3'b000, 0, 0, 0, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0);
        add("t2_req",    0, 3'b011, 3'b011, 3'b000, 0, 0, 0, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0);
        add("t2_own0",   0, 3'b011, 3'b011, 3'b000, 1, 0, 0, 3'b001, 3'b001, 3'b000, 3'b000, 1, 1);
        add("t2_hand",   0, 3'b010, 3'b010, 3'b000, 0, 0, 0, 3'b001, 3'b000, 3'b000, 3'b000, 0, 0);
        add("t2_own1",   0, 3'b010, 3'b010, 3'b010, 0, 0, 0, 3'b010, 3'b000, 3'b000, 3'b000, 1, 1);
        add("t4_err",    0, 3'b011, 3'b011, 3'b010, 0, 1, 0, 3'b010, 3'b000, 3'b010, 3'b000, 1, 1);
        add("t4_ack",    0, 3'b011, 3'b011, 3'b000, 1, 0, 0, 3'b010, 3'b010, 3'b000, 3'b000, 1, 1);
        add("t4_rty",    0, 3'b011, 3'b011, 3'b000, 0, 0, 1, 3'b010, 3'b000, 3'b000, 3'b010, 1, 1);
        add("t5_rst",    1, 3'b011, 3'b011, 3'b000, 1, 0, 0, 3'b010, 3'b010, 3'b000, 3'b000, 1, 1);
        add("t5_post",   0, 3'b011, 3'b011, 3'b000, 1, 0, 0, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0);
        add("t5_win0",   0, 3'b011, 3'b011, 3'b000, 0, 0, 0, 3'b001, 3'b000, 3'b000, 3'b000, 1, 1);
        add("t5_rel",    0, 3'b000, 3'b000, 3'b000, 0, 0, 0, 3'b001, 3'b000, 3'b000, 3'b000, 0, 0);
        add("t5_idle",   0, 3'b000, 3'b000, 3'b000, 0, 0, 0, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0);
        add("t6_req2",   0, 3'b100, 3'b100, 3'b100, 0, 0, 0, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0);
        add("t6_own2",   0, 3'b100, 3'b100, 3'b100, 1, 0, 0, 3'b100, 3'b100, 3'b000, 3'b000, 1, 1);
        add("t6_rel",    0, 3'b000, 3'b000, 3'b000, 0, 0, 0, 3'b100, 3'b000, 3'b000, 3'b000, 0, 0);
        add("t6_idle",   0, 3'b000, 3'b000, 3'b000, 0, 0, 0, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0);

        set_static(1'b1);
        do_reset();

        // Table-driven cycles: drive on the falling edge, check 1 ns later.
        foreach (vecs[k]) begin
            int o;
            @(negedge sys_clk);
            sys_rst = vecs[k].rst;
            m_cyc = vecs[k].cyc; m_stb = vecs[k].stb; m_we = vecs[k].we;
            s_ack = vecs[k].ack; s_err = vecs[k].err; s_rty = vecs[k].rty;
            #1;
            o = owner_of(vecs[k].exp_grant);
            check({vecs[k].name, ".grant"}, 64'(grant), 64'(vecs[k].exp_grant));
            check({vecs[k].name, ".m_ack"}, 64'(m_ack), 64'(vecs[k].exp_ack));
            check({vecs[k].name, ".m_err"}, 64'(m_err), 64'(vecs[k].exp_err));
            check({vecs[k].name, ".m_rty"}, 64'(m_rty), 64'(vecs[k].exp_rty));
            check({vecs[k].name, ".s_cyc"}, 64'(s_cyc), 64'(vecs[k].exp_s_cyc));
            check({vecs[k].name, ".s_stb"}, 64'(s_stb), 64'(vecs[k].exp_s_stb));
            check({vecs[k].name, ".s_we"}, 64'(s_we), (o >= 0) ? 64'(vecs[k].we[o]) : 64'd0);
            check({vecs[k].name, ".s_adr"}, 64'(s_adr), (o >= 0) ? 64'(adr_of(o)) : 64'd0);
            check({vecs[k].name, ".s_dat_ms"}, 64'(s_dat_ms), (o >= 0) ? 64'(dat_of(o)) : 64'd0);
            check({vecs[k].name, ".s_sel_cti_bte"}, 64'({s_sel, s_cti, s_bte}),
                  (o >= 0) ? 64'({sel_of(o), cti_of(o, 1'b1), 2'(o)}) : 64'd0);
            check({vecs[k].name, ".m_dat_sm"}, 64'(m_dat_sm), 64'h0000_0000_DEAD_BEEF);
        end

        // Round robin: all three request, each releases after 4 acks, two tenures each.
        set_static(1'b0);
        do_reset();
        for (int i = 0; i < NM; i++) begin
            acks[i] = 0; ten[i] = 0; drop[i] = 1'b0;
        end
        prev_g = '0; idle_cycles = 0; rr_done = 1'b0;
        for (int c = 0; c < 300 && !rr_done; c++) begin
            int o;
            @(negedge sys_clk);
            s_ack = 1'b0;
            for (int i = 0; i < NM; i++) begin
                m_cyc[i] = (ten[i] < 2) && !drop[i];
                drop[i]  = 1'b0;
            end
            m_stb = m_cyc;
            #1;
            o = owner_of(grant);
            if (o >= 0) begin
                if (grant != prev_g) owners.push_back(o);
                if (m_cyc[o]) begin
                    s_ack = 1'b1;
                    acks[o]++;
                    if (acks[o] == 4) begin
                        acks[o] = 0;
                        ten[o]++;
                        drop[o] = 1'b1;
                    end
                end
            end else if (owners.size() > 0) begin
                if (ten[0] == 2 && ten[1] == 2 && ten[2] == 2) rr_done = 1'b1;
                else idle_cycles++;
            end
            prev_g = grant;
        end
        check("rr_finished_in_budget", 64'(rr_done), 64'd1);
        check("rr_grant_count", 64'(owners.size()), 64'd6);
        for (int k = 0; k < 6; k++) begin
            if (k < owners.size()) check($sformatf("rr_owner_%0d", k), 64'(owners[k]), 64'(k % 3));
        end
        check("rr_idle_cycles", 64'(idle_cycles), 64'd0);

        // Quantum: master 0 reads continuously, master 1 joins; acks on every owned cycle.
        do_reset();
        s_ack = 1'b0;
        @(negedge sys_clk);
        m_cyc = 3'b001; m_stb = 3'b001;
        for (int c = 1; c <= 6; c++) begin
            @(negedge sys_clk);
            m_cyc = 3'b011; m_stb = 3'b011;
            s_ack = 1'b1;
            #1;
`ifdef WSHB_ARB_QUANTUM_EN
            q_exp = (c <= 4) ? 3'b001 : 3'b010;
`else
            q_exp = 3'b001;
`endif
            check($sformatf("quantum_grant_c%0d", c), 64'(grant), 64'(q_exp));
        end
        @(negedge sys_clk);
        m_cyc = '0; m_stb = '0; s_ack = 1'b0;
        repeat (2) @(negedge sys_clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wshb_arbiter_rr.md
# wshb_arbiter_rr

Parametrised N-master Wishbone B4 (classic, registered-feedback tags passed through) arbiter with round-robin grant, placed on the `sys_clk` domain between the video-path masters (test-pattern generator, VGA frame fetcher, future stream writer) and the single SDRAM slave port of the hardware support block. It replaces the fixed two-master interconnect: the master count is a parameter and fairness is guaranteed. An optional quantum mode lets a waiting master take the bus from a long-running owner at transfer boundaries.

## Interface
Parameters:
- `NM`, 2: number of masters (2..8).
- `AW`, 32: address width.
- `DW`, 32: data width; `DW/8` select bits.
- `QUANTUM`, 16: acks an owner may collect before it can be pre-empted (used only with `WSHB_ARB_QUANTUM_EN`, range 1..255).

Ports (clock and reset first):
- `sys_clk`  in  1  system clock, 100 MHz; single clock domain.
- `sys_rst`  in  1  reset, synchronous, active-high.
- `m_cyc`  in  NM  per-master cycle request.
- `m_stb`  in  NM  per-master strobe.
- `m_we`  in  NM  per-master write enable.
- `m_adr`  in  NM*AW  packed addresses, master i at [i*AW +: AW].
- `m_dat_ms`  in  NM*DW  packed write data.
- `m_sel`  in  NM*DW/8  packed byte selects.
- `m_cti`  in  NM*3  packed cycle-type identifiers.
- `m_bte`  in  NM*2  packed burst-type extensions.
- `m_ack`, `m_err`, `m_rty`  out  NM each  per-master termination, only the owner's bit may be 1.
- `m_dat_sm`  out  DW  read data, broadcast to all masters.
- `s_cyc`, `s_stb`, `s_we`  out  1 each  to slave.
- `s_adr`  out  AW; `s_dat_ms`  out  DW; `s_sel`  out  DW/8; `s_cti`  out  3; `s_bte`  out  2.
- `s_ack`, `s_err`, `s_rty`  in  1 each; `s_dat_sm`  in  DW.
- `grant`  out  NM  registered one-hot owner, 0 when bus free.

## Operation
- States: `IDLE` (`grant`=0) and `OWNED` (`grant` one-hot).
- Arbitration point: any edge where state is `IDLE`, or the owner's `m_cyc` is 0, or (quantum mode) a pre-emption is due. At that edge `grant` <= first requester with `m_cyc`=1 searching from index `last+1` upward, wrapping modulo `NM`; if none, `grant` <= 0 (`IDLE`). `last` <= index of the new owner.
- While `OWNED`: all `s_*` request outputs are the owner's fields muxed combinationally; `s_cyc` = owner `m_cyc`, `s_stb` = owner `m_stb`. Owner's `m_ack/m_err/m_rty` = `s_ack/s_err/s_rty`; all other bits 0.
- Non-owners holding `m_cyc`/`m_stb` see no termination and simply wait; nothing is dropped.
- `IDLE`: `s_cyc`=`s_stb`=`s_we`=0, `s_adr`/`s_dat_ms`/`s_sel`/`s_cti`/`s_bte`=0, all `m_ack/m_err/m_rty`=0.
- `m_dat_sm` = `s_dat_sm` unconditionally.
- Reset values: `grant`=0, state `IDLE`, `last`=`NM-1` (so master 0 wins the first arbitration), quantum counter 0; all outputs as `IDLE`.
- Reset asserted mid-transfer: at that edge `grant` <= 0, bus returns to `IDLE`; pending slave acks after reset are discarded (no owner).
- `s_ack`, `s_err`, `s_rty` are mutually exclusive at the slave; arbiter does not check.

## Timing
- Request-to-grant: 1 cycle. `m_cyc` rising at edge k (sampled) -> `grant` and `s_cyc` valid after edge k+1 when bus free.
- Handover: owner drops `m_cyc` before edge k; at edge k `grant` moves directly to next requester — zero idle cycles between owners.
- Termination path is combinational (`s_ack` -> `m_ack` same cycle); no added latency per beat.
- Grant never changes while owner `m_cyc`=1, except quantum pre-emption.

## Configuration
- Macro `WSHB_ARB_QUANTUM_EN`.
- Defined: 8-bit counter counts owner acks, cleared on each new grant. When count >= `QUANTUM`, and an ack occurs with owner `m_cti` = 3'b000 or 3'b111 (no burst in progress), and another master has `m_cyc`=1, that edge is an arbitration point; the old owner keeps `m_cyc` and queues as a normal requester.
- Not defined: counter absent; owner keeps the bus until it drops `m_cyc`.

## Test plan
- Single master 0, single read, slave acks 2 cycles after `s_stb` -> `grant`=0b01 one cycle after request, `m_ack[0]` pulses once, `m_dat_sm`=slave data 0xDEADBEEF.
- After reset, masters 0 and 1 request on the same edge -> `grant`=0b01, then 0b10 on the edge master 0 drops `m_cyc`, no idle cycle.
- `NM`=3, all masters request continuously, each releases after 4 acks -> grant sequence 0,1,2,0,1,2; no master starved.
- Slave returns `s_err` to owner 1 while master 0 waits -> `m_err`=0b010 only, `m_ack`=0.
- `sys_rst` high mid-burst of master 1 -> next cycle `grant`=0, `s_cyc`=0; after release master 0 wins first.
- With `WSHB_ARB_QUANTUM_EN`, `QUANTUM`=4, master 0 single reads continuously, master 1 requests -> grant moves to master 1 after master 0's 4th ack; without macro master 0 keeps the bus.
